seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit stays enabled, >=2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 inverts seg_out and an_out at the pins.
REQ-004 Port clk  input  1  sole clock, all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port digits  input  4*NUM_DIGITS  BCD nibbles; nibble 0 [3:0] is the least significant digit.
REQ-007 Port blank_mask  input  NUM_DIGITS  bit i=1 forces digit i dark.
REQ-008 Port load  input  1  one-cycle strobe to capture digits and blank_mask.
REQ-009 Port seg_out  output  7  segments, bit6=a .. bit0=g.
REQ-010 Port an_out  output  NUM_DIGITS  one-hot digit enable.
REQ-011 Port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-012 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-013 frame_done SHALL be high for exactly the one cycle in which the index wraps to 0, i.e. once per NUM_DIGITS*SCAN_DIV cycles.
REQ-014 load=1 SHALL capture digits/blank_mask into a pending register and set a pending flag; a later load overwrites pending.
REQ-015 Pending contents SHALL transfer to the display register only in the index-wrap cycle, then clear the flag; mid-frame display never changes (no tearing).
REQ-016 load coincident with the wrap cycle SHALL transfer the newly presented values directly; the flag ends clear.
REQ-017 Decode (logical, active-high): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-018 Nibble values 10..15 SHALL decode to all segments off.
REQ-019 A blanked digit SHALL drive all segments off while its an_out bit is still enabled.
REQ-020 seg_out and an_out SHALL be registered: they reflect the index and display register of the previous cycle (latency 1).
REQ-021 Exactly one an_out bit SHALL be active (logical) at any time outside reset.
REQ-022 ACTIVE_LOW=1 SHALL invert every seg_out and an_out bit after decode; frame_done is never inverted.

Reset
REQ-023 rst=1 SHALL clear scan counter, index, pending/display registers, pending flag, frame_done.
REQ-024 During reset and the first cycle after release, seg_out and an_out SHALL be logically all-off (pins all-1 when ACTIVE_LOW=1).
REQ-025 Reset asserted mid-frame SHALL take effect at the next edge and discard any pending load.

Configuration
REQ-026 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digits valued 0 that are more significant than the most significant nonzero digit SHALL be blanked; digit 0 never blanked by this rule; OR-ed with blank_mask.
REQ-027 Macro undefined: only blank_mask and REQ-018 blank digits; no leading-zero logic synthesised.

Structure
REQ-028 Package seg7_pkg SHALL hold the 7-bit segment encoding constants, SEG_OFF, and the 4-bit digit typedef.
REQ-029 Decode SHALL live in sub-module seg7_digit_dec (4-bit in, 7-bit logical out, combinational), one instance on the selected nibble.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1 unless stated)
REQ-030 rst held 3 cycles, released -> an_out=4'b1111, seg_out=7'b1111111, frame_done=0 through first post-reset cycle; frame_done first pulses 16 cycles after release.
REQ-031 load digits=16'h1234 mid-frame -> unchanged display until wrap; next frame digit 0 shows seg_out=7'b1001100 (4 inverted) with an_out=4'b1110.
REQ-032 digits=16'h00F9 loaded -> digit 1 dark (seg_out=7'b1111111), digit 0 shows 9 = 7'b0000100.
REQ-033 digits=16'h0070 with SEG7_LEADING_ZERO_BLANK_EN -> digits 3,2 dark, digit 1 shows 7, digit 0 shows 0; macro undefined -> all four lit.
REQ-034 load=1 exactly in wrap cycle with 16'h5555 -> that frame shows 5 (7'b0100100) on every digit.
REQ-035 rst pulsed during digit 2 with pending load -> next cycle outputs all-off, index 0, old display content 0, pending discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the seven-segment scan driver.
// Segment vectors are logical (1 = lit), ordered bit6=a .. bit0=g.
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;
  localparam seg_t SEG_0   = 7'b1111110;
  localparam seg_t SEG_1   = 7'b0110000;
  localparam seg_t SEG_2   = 7'b1101101;
  localparam seg_t SEG_3   = 7'b1111001;
  localparam seg_t SEG_4   = 7'b0110011;
  localparam seg_t SEG_5   = 7'b1011011;
  localparam seg_t SEG_6   = 7'b1011111;
  localparam seg_t SEG_7   = 7'b1110000;
  localparam seg_t SEG_8   = 7'b1111111;
  localparam seg_t SEG_9   = 7'b1111011;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD to seven-segment decoder, logical (active-high) output.
// Non-BCD nibble values decode to all segments off.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with tear-free frame-boundary updates.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d, disp_mask_q, disp_mask_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   blank_all;
  logic [3:0]              sel_nib;
  logic                    sel_blank;
  logic [6:0]              dec_seg;

  assign tick = (cnt_q == CntLast);
  assign wrap = tick && (idx_q == IdxLast);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      lz_run      = lz_run & (disp_dig_q[4*i +: 4] == 4'd0);
      lz_blank[i] = lz_run;
    end
  end

  assign blank_all = disp_mask_q | lz_blank;
`else
  assign blank_all = disp_mask_q;
`endif

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    pend_dig_d  = pend_dig_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    disp_dig_d  = disp_dig_q;
    disp_mask_d = disp_mask_q;
    fd_d        = wrap;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Display only changes at the frame boundary; a load in that same cycle wins.
    if (wrap) begin
      if (load) begin
        disp_dig_d  = digits;
        disp_mask_d = blank_mask;
      end else if (pend_vld_q) begin
        disp_dig_d  = pend_dig_q;
        disp_mask_d = pend_mask_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_dig_d  = digits;
      pend_mask_d = blank_mask;
      pend_vld_d  = 1'b1;
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    an_d      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib   = disp_dig_q[4*i +: 4];
        sel_blank = blank_all[i];
        an_d[i]   = 1'b1;
      end
    end
    seg_d = sel_blank ? SEG_OFF : dec_seg;
  end

  seg7_digit_dec u_dec (
    .bcd (sel_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_dig_q  <= '0;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
      disp_dig_q  <= '0;
      disp_mask_q <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_dig_q  <= pend_dig_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
      disp_dig_q  <= disp_dig_d;
      disp_mask_q <= disp_mask_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign seg_out    = ACTIVE_LOW ? ~seg_q : seg_q;
  assign an_out     = ACTIVE_LOW ? ~an_q : an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle scan, active-low pins).
// The reference derives display contents from timestamped loads and frame arithmetic.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  blank_mask = '0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blank_mask (blank_mask),
    .load       (load),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        fd;
    logic        rs;
  } exp_t;

  typedef struct packed {
    logic [31:0] s;
    logic [15:0] d;
    logic [3:0]  m;
  } load_t;

  int    tick = 0;
  int    tests = 0;
  int    fails = 0;
  exp_t  exp_q[$];
  string name_q[$];
  load_t loads[$];
  int    rel = 0;
  bit    valid = 1'b0;
  string phase = "reset";

  always @(posedge clk) tick <= tick + 1;

  function automatic logic [6:0] ref_seg(input int n);
    case (n)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Shown contents = last load sampled before the start of the frame containing r.
  function automatic void disp_at(input int r, output logic [15:0] d, output logic [3:0] m);
    int f;
    f = (r / FR) * FR;
    d = '0;
    m = '0;
    foreach (loads[i]) begin
      if (int'(loads[i].s) < f) begin
        d = loads[i].d;
        m = loads[i].m;
      end
    end
  endfunction

  task automatic step(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] m);
    exp_t        e;
    logic [15:0] dd;
    logic [3:0]  dm;
    int          idx;
    int          nib;
    bit          blank;
    load_t       l;
    @(posedge clk);
    #1;
    rst        = r;
    load       = ld;
    digits     = d;
    blank_mask = m;
    if (valid) begin
      e.due = 32'(tick + 1);
      e.rs  = r;
      if (r) begin
        e.seg = 7'h7F;
        e.an  = 4'hF;
        e.fd  = 1'b0;
      end else begin
        disp_at(rel, dd, dm);
        idx   = (rel / SD) % ND;
        nib   = int'((dd >> (4 * idx)) & 16'hF);
        blank = dm[idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0 && (dd >> (4 * idx)) == 16'h0) blank = 1'b1;
`endif
        e.seg = ~(blank ? 7'h00 : ref_seg(nib));
        e.an  = ~(4'b0001 << idx);
        e.fd  = ((rel + 1) % FR) == 0;
      end
      exp_q.push_back(e);
      name_q.push_back(phase);
    end
    if (r) begin
      loads.delete();
      rel   = 0;
      valid = 1'b1;
    end else begin
      if (ld) begin
        l.s = 32'(rel);
        l.d = d;
        l.m = m;
        loads.push_back(l);
      end
      rel++;
    end
  endtask

  task automatic idle_to(input int pos);
    do step(1'b0, 1'b0, 16'h0, 4'h0); while ((rel % FR) != pos);
  endtask

  exp_t  mon_e;
  string mon_n;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].due) <= tick) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      tests++;
      if (int'(mon_e.due) != tick) begin
        fails++;
        $display("FAIL %s expired wait: tick=%0d due=%0d", mon_n, tick, mon_e.due);
      end else if (mon_e.rs) begin
        if (seg_out !== 7'h7F || an_out !== 4'hF || frame_done !== 1'b0) begin
          fails++;
          $display("FAIL %s reset state tick=%0d seg=%b an=%b frame_done=%b",
                   mon_n, tick, seg_out, an_out, frame_done);
        end
      end else if (seg_out !== mon_e.seg || an_out !== mon_e.an ||
                   frame_done !== mon_e.fd) begin
        fails++;
        $display("FAIL %s tick=%0d seg=%b want %b an=%b want %b frame_done=%b want %b",
                 mon_n, tick, seg_out, mon_e.seg, an_out, mon_e.an, frame_done, mon_e.fd);
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    logic [15:0] d;
    logic [3:0]  m;
    bit          r;
    bit          ld;

    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
    phase = "post_reset_frame";
    idle_to(5);
    phase = "load_1234_midframe";
    step(1'b0, 1'b1, 16'h1234, 4'h0);
    idle_to(5);
    phase = "load_00F9";
    step(1'b0, 1'b1, 16'h00F9, 4'h0);
    idle_to(5);
    phase = "load_0070";
    step(1'b0, 1'b1, 16'h0070, 4'h0);
    idle_to(15);
    phase = "load_5555_at_wrap";
    step(1'b0, 1'b1, 16'h5555, 4'h0);
    idle_to(7);
    phase = "load_masked";
    step(1'b0, 1'b1, 16'h8642, 4'b0101);
    idle_to(9);
    phase = "reset_with_pending";
    step(1'b0, 1'b1, 16'h9876, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (40) step(1'b0, 1'b0, 16'h0, 4'h0);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      rnd = $urandom;
      d   = rnd[15:0];
      if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
      if ($urandom_range(0, 3) == 0) d = d & 16'h0F0F;
      rnd = $urandom;
      m   = ($urandom_range(0, 3) == 0) ? rnd[3:0] : 4'h0;
      step(r, ld, d, m);
    end
    phase = "drain";
    repeat (4) step(1'b0, 1'b0, 16'h0, 4'h0);
    repeat (5) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never checked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
